seg7_scan_mux: RTL
==================

// Module: seg7_scan_mux
// PURPOSE
//  N-digit multiplexed seven-segment driver. Successor to the fixed 4-digit scanner.
//  Adds a slot prescaler, tear-free shadow loading, per-digit DP and blanking, and leading-zero blanking.
//  Adds PWM brightness, an anti-ghost dead cycle and output polarity control.
//  Sits between display-value logic and the board's segment/digit-select pins.
// PARAMETERS
//  N_DIGITS        4    number of digits, >=1; index 0 = least significant
//  PRE_W           10   slot length = 2**PRE_W scan_clk cycles per digit
//  BRIGHT_W        3    brightness resolution, 1..PRE_W
//  SEG_ACTIVE_LOW  1    1: seg/dp low = lit (common anode)
//  SEL_ACTIVE_LOW  1    1: dig_sel low = digit enabled
// PORTS
//  scan_clk     in   1            scan clock
//  rst_n        in   1            reset, asynchronous, active-low
//  digits_i     in   4*N_DIGITS   hex nibbles; digit k = [4k+3:4k]
//  dp_i         in   N_DIGITS     decimal point request per digit
//  blank_i      in   N_DIGITS     force digit dark
//  lzb_en       in   1            leading-zero blanking enable
//  brightness   in   BRIGHT_W     0 = off, all-ones = full on
//  load         in   1            one-cycle pulse: capture digits_i/dp_i/blank_i
//  seg          out  7            {a,b,c,d,e,f,g}
//  dp           out  1            decimal point
//  dig_sel      out  N_DIGITS     digit enables; bit k drives digit k
//  frame_start  out  1            one-cycle pulse at each frame commit
// BEHAVIOUR
//  - Reset (async):
//    - cnt=0, idx=0, pending/active regs=0, frame_start=0.
//    - seg/dp/dig_sel at their inactive level: all 1s when *_ACTIVE_LOW=1.
//  - Prescaler: cnt[PRE_W-1:0] increments every cycle, wraps freely.
//    - slot_end = (cnt == all-ones).
//  - Digit index idx advances at slot_end and wraps N_DIGITS-1 -> 0.
//  - Shadow loading:
//    - load captures inputs into pending.
//    - At frame boundary (slot_end && idx==N_DIGITS-1), active <= pending.
//    - If load coincides with the boundary, the new inputs go directly to active and pending.
//    - Display never changes mid-frame.
//  - frame_start: registered pulse in the cycle after a frame boundary, with idx=0.
//  - LZB: with lzb_en=1, digit k>0 is blanked when it and all higher digits are 0 in active.
//    - Digit 0 is never LZB-blanked.
//    - An active DP on digit k disables LZB for digit k and all lower digits.
//  - Lit condition for current idx:
//    - lit = cnt!=0 (anti-ghost dead cycle)
//    - && (brightness==all-ones || cnt[PRE_W-1 -: BRIGHT_W] < brightness)
//    - && !blank_active[idx] && !lzb_blank[idx].
//  - Outputs are registered, valid 1 cycle after cnt/idx. When lit:
//    - dig_sel is one-hot on idx.
//    - seg = hex pattern of active digit idx; dp = active dp[idx].
//    - Else all inactive.
//  - Hex pattern, active-high abcdefg: 0=1111110, 1=0110000, 8=1111111, A=1110111, F=1000111.
//    - b, d render lowercase. Invert per polarity parameter.
//  - At most one dig_sel bit active in any cycle. No X propagation from an unloaded state (all zeros).
// STRUCTURE
//  - Package seg7_pkg:
//    - function hex_to_seg(logic[3:0]) -> logic[6:0], active-high.
//    - SEG_OFF and SEL_OFF constants per polarity.
//  - Sub-module seg7_lzb (combinational, N_DIGITS param): active digits + dp -> blank mask.
//  - Prescaler, index, shadow regs and output regs stay in this module.
// TESTING
//  1. Reset mid-slot with PRE_W=4:
//     - seg=7'h7F, dp=1, dig_sel=4'hF immediately.
//     - After release, first lit cycle is cnt=1, digit 0.
//  2. load 16'h1234 mid-frame:
//     - Old value held until frame_start.
//     - Then digit 0 shows 4 (seg=7'b1001100 active-low), digit 3 shows 1.
//  3. lzb_en=1, digits 16'h0050:
//     - Digits 3 and 2 dark; digit 1 shows 5, digit 0 shows 0.
//     - Same with dp_i[2]=1: digit 2 shows 0 plus DP.
//  4. PRE_W=4, BRIGHT_W=2:
//     - brightness=1 -> lit cnt 1..3 only.
//     - brightness=3 -> lit cnt 1..15.
//     - brightness=0 -> never lit.
//  5. load asserted exactly at frame boundary -> new value visible in the next frame; pending equals it.
//  6. N_DIGITS=1:
//     - frame_start every 2**PRE_W cycles.
//     - dig_sel toggles only for dead cycle/PWM.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// segment decode table and the idle (dark) output levels for each polarity.
package seg7_pkg;

    // Dark levels: *_LOW for active-low pins, *_HIGH for active-high pins
    localparam logic [6:0] SEG_OFF_LOW  = 7'h7F;
    localparam logic [6:0] SEG_OFF_HIGH = 7'h00;
    localparam logic       SEL_OFF_LOW  = 1'b1;
    localparam logic       SEL_OFF_HIGH = 1'b0;

    // Active-high {a,b,c,d,e,f,g}; b and d are drawn lowercase
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1111110;
            4'h1:    pat = 7'b0110000;
            4'h2:    pat = 7'b1101101;
            4'h3:    pat = 7'b1111001;
            4'h4:    pat = 7'b0110011;
            4'h5:    pat = 7'b1011011;
            4'h6:    pat = 7'b1011111;
            4'h7:    pat = 7'b1110000;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1111011;
            4'hA:    pat = 7'b1110111;
            4'hB:    pat = 7'b0011111;
            4'hC:    pat = 7'b1001110;
            4'hD:    pat = 7'b0111101;
            4'hE:    pat = 7'b1001111;
            default: pat = 7'b1000111;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_lzb.sv
// Leading-zero blanking mask: walks from the most significant digit down,
// blanking zeros until a non-zero digit or a lit decimal point is seen.
module seg7_lzb
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                     en,
    input  logic [N_DIGITS-1:0][3:0] digits,
    input  logic [N_DIGITS-1:0]      dp,
    output logic [N_DIGITS-1:0]      blank
);

    always_comb begin
        logic zero_run;
        logic dp_seen;
        blank    = '0;
        zero_run = 1'b1;
        dp_seen  = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (digits[k] == 4'h0);
            dp_seen  = dp_seen || dp[k];
            // Digit 0 always shows, so a value of zero still reads "0"
            blank[k] = en && (k != 0) && zero_run && !dp_seen;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed seven-segment driver with slot prescaler, frame-aligned
// shadow registers, leading-zero blanking, PWM dimming and a dead cycle per slot.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int PRE_W          = 10,
    parameter int BRIGHT_W       = 3,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit SEL_ACTIVE_LOW = 1
) (
    input  logic                  scan_clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    input  logic                  lzb_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   dig_sel,
    output logic                  frame_start
);

    localparam int                   IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]           SEG_OFF  = SEG_ACTIVE_LOW ? SEG_OFF_LOW : SEG_OFF_HIGH;
    localparam logic                 DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0]  SEL_OFF  =
        {N_DIGITS{SEL_ACTIVE_LOW ? SEL_OFF_LOW : SEL_OFF_HIGH}};

    logic [PRE_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic                      slot_end;
    logic                      frame_end;

    logic [N_DIGITS-1:0][3:0]  pend_dig, act_dig;
    logic [N_DIGITS-1:0]       pend_dp, act_dp;
    logic [N_DIGITS-1:0]       pend_blank, act_blank;
    logic [N_DIGITS-1:0]       lzb_blank;

    logic [N_DIGITS-1:0]       cur_sel;
    logic [3:0]                cur_dig;
    logic                      cur_dp;
    logic                      cur_dark;
    logic                      pwm_on;
    logic                      lit;

    assign slot_end  = &cnt;
    assign frame_end = slot_end && (idx == LAST_IDX);

    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (slot_end)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Active set only changes on the frame boundary so a frame is never torn
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_dig    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            if (load) begin
                pend_dig   <= digits_i;
                pend_dp    <= dp_i;
                pend_blank <= blank_i;
            end
            if (frame_end) begin
                act_dig   <= load ? digits_i : pend_dig;
                act_dp    <= load ? dp_i     : pend_dp;
                act_blank <= load ? blank_i  : pend_blank;
            end
        end
    end

    seg7_lzb #(.N_DIGITS(N_DIGITS)) u_lzb (
        .en     (lzb_en),
        .digits (act_dig),
        .dp     (act_dp),
        .blank  (lzb_blank)
    );

    // One-hot decode of idx doubles as the read mux select
    always_comb begin
        cur_sel  = '0;
        cur_dig  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            cur_sel[k] = (idx == IDX_W'(k));
            if (cur_sel[k]) begin
                cur_dig  = act_dig[k];
                cur_dp   = act_dp[k];
                cur_dark = act_blank[k] || lzb_blank[k];
            end
        end
    end

    assign pwm_on = (brightness == '1) || (cnt[PRE_W-1 -: BRIGHT_W] < brightness);
    // cnt==0 is the anti-ghost gap between digits
    assign lit    = (cnt != '0) && pwm_on && !cur_dark;

    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            dig_sel     <= SEL_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (lit) begin
                seg     <= SEG_ACTIVE_LOW ? ~hex_to_seg(cur_dig) : hex_to_seg(cur_dig);
                dp      <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
                dig_sel <= SEL_ACTIVE_LOW ? ~cur_sel : cur_sel;
            end else begin
                seg     <= SEG_OFF;
                dp      <= DP_OFF;
                dig_sel <= SEL_OFF;
            end
        end
    end

endmodule
